// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback merge logic.
// Holds the datapath widths, the register count and the record stored
// per buffered multi-cycle-unit result.
package wb_pkg;

   localparam int DATA_W = 32;
   localparam int RN_W   = 5;
   localparam int NREG   = 32;

   // One buffered multi-cycle result; valid drops when a newer pipeline
   // write to the same register supersedes it.
   typedef struct packed {
      logic              valid;
      logic [RN_W-1:0]   wn;
      logic [DATA_W-1:0] d;
   } wb_entry_t;

   // Write source chosen by the arbiter each cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_HEAD = 2'd2,
      SRC_BYP  = 2'd3
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for multi-cycle-unit results waiting for a free
// register-file write slot.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_wn/d     enqueue a result at the tail
//   pop                 dequeue the head (ignored when empty)
//   squash_en/wn        invalidate every stored entry targeting squash_wn
//   head                entry currently at the head
//   empty, full         occupancy status
//   pend                bit i set while a valid entry targets register i
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [RN_W-1:0]   push_wn,
   input  logic [DATA_W-1:0] push_d,
   input  logic              pop,
   input  logic              squash_en,
   input  logic [RN_W-1:0]   squash_wn,
   output wb_entry_t         head,
   output logic              empty,
   output logic              full,
   output logic [NREG-1:0]   pend
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [RN_W-1:0]   wn_q   [DEPTH];
   logic [RN_W-1:0]   wn_d   [DEPTH];
   logic [DATA_W-1:0] dat_q  [DEPTH];
   logic [DATA_W-1:0] dat_d  [DEPTH];
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_push, do_pop;

   // The counter, not the pointers, tells full from empty: both pointers
   // are equal in either case.
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == DEPTH_C);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign head.valid = vld_q[rd_ptr_q];
   assign head.wn    = wn_q[rd_ptr_q];
   assign head.d     = dat_q[rd_ptr_q];

   always_comb begin
      wn_d     = wn_q;
      dat_d    = dat_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      // Squashed entries keep their slot; they are simply skipped at the head.
      if (squash_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wn_q[i] == squash_wn) vld_d[i] = 1'b0;
         end
      end

      // Clearing valid on pop keeps valid bits meaningful only for occupied slots.
      if (do_pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + 1'b1;
      end

      if (do_push) begin
         wn_d[wr_ptr_q]  = push_wn;
         dat_d[wr_ptr_q] = push_d;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end

      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) pend[wn_q[i]] = 1'b1;
      end
      pend[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
      wn_q  <= wn_d;
      dat_q <= dat_d;
   end

endmodule

// File: rtl/wb_merge.sv
// Merges the pipeline writeback stream with results from a multi-cycle
// unit (mul/div) onto a single register-file write port. Pipeline writes
// always win; multi-cycle results are buffered in order and drained in
// free cycles, and a pipeline write squashes any older buffered result
// for the same register.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   p_we, p_wn, p_d       pipeline writeback (never stalled)
//   m_valid, m_wn, m_d    multi-cycle result offer
//   m_ready               buffer not full (transfer on m_valid & m_ready)
//   we, wn, d             registered register-file write
//   pend                  registers with a buffered result outstanding
module wb_merge
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_we,
   input  logic [RN_W-1:0]   p_wn,
   input  logic [DATA_W-1:0] p_d,
   input  logic              m_valid,
   input  logic [RN_W-1:0]   m_wn,
   input  logic [DATA_W-1:0] m_d,
   output logic              m_ready,
   output logic              we,
   output logic [RN_W-1:0]   wn,
   output logic [DATA_W-1:0] d,
   output logic [NREG-1:0]   pend
);

   wb_src_e           src;
   wb_entry_t         head;
   logic              fifo_empty, fifo_full;
   logic              pipe_sel, m_fire, m_squash, push, pop;
   logic              we_q, we_d;
   logic [RN_W-1:0]   wn_q, wn_d;
   logic [DATA_W-1:0] d_q, d_d;

   // Ready comes from registered occupancy only, never from m_valid.
   assign m_ready  = ~fifo_full;
   assign m_fire   = m_valid & m_ready;
   assign pipe_sel = p_we & (p_wn != '0);

   always_comb begin
      src = SRC_NONE;
      if (pipe_sel)                       src = SRC_PIPE;
      else if (!fifo_empty)               src = SRC_HEAD;
      else if (m_fire && (m_wn != '0))    src = SRC_BYP;
   end

   // A same-cycle transfer to the register the pipeline is writing is stale
   // and is dropped; results for register 0 are accepted and discarded.
   assign m_squash = pipe_sel && (m_wn == p_wn);
   assign push     = m_fire && (m_wn != '0) && (src != SRC_BYP) && !m_squash;
   assign pop      = (src == SRC_HEAD);

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_wn   (m_wn),
      .push_d    (m_d),
      .pop       (pop),
      .squash_en (pipe_sel),
      .squash_wn (p_wn),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .pend      (pend)
   );

   always_comb begin
      we_d = 1'b0;
      wn_d = wn_q;
      d_d  = d_q;
      case (src)
         SRC_PIPE: begin
            we_d = 1'b1;
            wn_d = p_wn;
            d_d  = p_d;
         end
         SRC_HEAD: begin
            // An invalidated head still costs its cycle but writes nothing.
            if (head.valid) begin
               we_d = 1'b1;
               wn_d = head.wn;
               d_d  = head.d;
            end
         end
         SRC_BYP: begin
            we_d = 1'b1;
            wn_d = m_wn;
            d_d  = m_d;
         end
         default: begin
            we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q <= 1'b0;
         wn_q <= '0;
         d_q  <= '0;
      end else begin
         we_q <= we_d;
         wn_q <= wn_d;
         d_q  <= d_d;
      end
   end

   assign we = we_q;
   assign wn = wn_q;
   assign d  = d_q;

endmodule

// File: tb/tb_wb_merge.sv
// Directed scoreboard bench for wb_merge: stimulus pushes the writes it
// expects, an independent monitor pops and compares on every we pulse.
module tb_wb_merge;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_we;
   logic [4:0]  p_wn;
   logic [31:0] p_d;
   logic        m_valid;
   logic [4:0]  m_wn;
   logic [31:0] m_d;
   logic        m_ready;
   logic        we;
   logic [4:0]  wn;
   logic [31:0] d;
   logic [31:0] pend;

   typedef struct {
      logic [4:0]  wn;
      logic [31:0] d;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 1'b0;

   wb_merge #(.DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .p_we    (p_we),
      .p_wn    (p_wn),
      .p_d     (p_d),
      .m_valid (m_valid),
      .m_wn    (m_wn),
      .m_d     (m_d),
      .m_ready (m_ready),
      .we      (we),
      .wn      (wn),
      .d       (d),
      .pend    (pend)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] ewn, input logic [31:0] ed);
      exp_t e;
      e.wn = ewn;
      e.d  = ed;
      expq.push_back(e);
   endtask

   task automatic idle();
      p_we    = 1'b0;
      m_valid = 1'b0;
   endtask

   // Monitor: every register-file write must match the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!done && we === 1'b1) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got wn=%0d d=%0h required no write", wn, d);
         end else begin
            e = expq.pop_front();
            check("wr_wn", 32'(wn), 32'(e.wn));
            check("wr_d", d, e.d);
         end
      end
   end

   initial begin
      rst = 1'b1;
      p_we = 1'b0; p_wn = '0; p_d = '0;
      m_valid = 1'b0; m_wn = '0; m_d = '0;
      step();
      step();
      check("rst_we", 32'(we), 32'd0);
      check("rst_wn", 32'(wn), 32'd0);
      check("rst_d", d, 32'd0);
      check("rst_ready", 32'(m_ready), 32'd1);
      check("rst_pend", pend, 32'd0);
      rst = 1'b0;

      // Pipeline only.
      p_we = 1'b1; p_wn = 5'd5; p_d = 32'h1234;
      expect_wr(5'd5, 32'h0000_1234);
      step();
      idle();
      check("pipe_pend", pend, 32'd0);
      step();

      // Bypass of an m transfer into an empty buffer.
      m_valid = 1'b1; m_wn = 5'd7; m_d = 32'hCAFE;
      expect_wr(5'd7, 32'h0000_CAFE);
      step();
      idle();
      check("byp_pend", pend, 32'd0);
      check("byp_ready", 32'(m_ready), 32'd1);
      step();
      check("byp_no_second_write", 32'(we), 32'd0);

      // Conflict: pipeline busy for 5 cycles, m fills the buffer with 8..11,
      // a fifth offer (reg 12) must be refused.
      for (int k = 0; k < 5; k++) begin
         p_we = 1'b1; p_wn = 5'd3; p_d = 32'h300 + k;
         expect_wr(5'd3, 32'h300 + k);
         m_valid = 1'b1;
         if (k < 4) begin
            m_wn = 5'(8 + k); m_d = 32'hA0 + k;
            check("fill_ready", 32'(m_ready), 32'd1);
         end else begin
            m_wn = 5'd12; m_d = 32'hDEAD;
            check("full_ready", 32'(m_ready), 32'd0);
            check("full_pend", pend, 32'h0000_0F00);
         end
         step();
      end
      idle();
      expect_wr(5'd8,  32'hA0);
      expect_wr(5'd9,  32'hA1);
      expect_wr(5'd10, 32'hA2);
      expect_wr(5'd11, 32'hA3);
      step();
      check("drain_pend1", pend, 32'h0000_0E00);
      step();
      check("drain_pend2", pend, 32'h0000_0C00);
      step();
      check("drain_pend3", pend, 32'h0000_0800);
      step();
      check("drain_pend4", pend, 32'd0);
      check("drain_ready", 32'(m_ready), 32'd1);

      // Squash of a buffered entry by a newer pipeline write.
      p_we = 1'b1; p_wn = 5'd4; p_d = 32'h44;
      m_valid = 1'b1; m_wn = 5'd9; m_d = 32'hAAAA;
      expect_wr(5'd4, 32'h44);
      step();
      m_valid = 1'b0;
      check("sq_pend_queued", pend, 32'h0000_0200);
      p_wn = 5'd9; p_d = 32'hBBBB;
      expect_wr(5'd9, 32'hBBBB);
      step();
      idle();
      check("sq_pend_cleared", pend, 32'd0);
      step();
      check("sq_drop_we", 32'(we), 32'd0);
      check("sq_ready", 32'(m_ready), 32'd1);

      // Squash of a same-cycle m transfer.
      p_we = 1'b1; p_wn = 5'd6; p_d = 32'h66;
      m_valid = 1'b1; m_wn = 5'd6; m_d = 32'h77;
      expect_wr(5'd6, 32'h66);
      step();
      idle();
      check("sq_same_pend", pend, 32'd0);
      step();
      check("sq_same_we", 32'(we), 32'd0);

      // Register 0 from both sources never writes.
      p_we = 1'b1; p_wn = 5'd0; p_d = 32'hDEAD;
      m_valid = 1'b1; m_wn = 5'd0; m_d = 32'hBEEF;
      step();
      idle();
      check("r0_we", 32'(we), 32'd0);
      check("r0_pend", pend, 32'd0);
      // Four reg-0 transfers during pipeline writes must not fill the buffer.
      for (int k = 0; k < 4; k++) begin
         p_we = 1'b1; p_wn = 5'd2; p_d = 32'h20 + k;
         m_valid = 1'b1; m_wn = 5'd0; m_d = 32'h5000 + k;
         expect_wr(5'd2, 32'h20 + k);
         step();
      end
      idle();
      check("r0_ready", 32'(m_ready), 32'd1);
      step();
      check("r0_idle_we", 32'(we), 32'd0);

      // Reset mid-drain with three entries left and a transfer in flight.
      for (int k = 0; k < 4; k++) begin
         p_we = 1'b1; p_wn = 5'd1; p_d = 32'h10 + k;
         m_valid = 1'b1; m_wn = 5'(12 + k); m_d = 32'hC0 + k;
         expect_wr(5'd1, 32'h10 + k);
         step();
      end
      idle();
      expect_wr(5'd12, 32'hC0);
      step();
      check("rd_pend_before", pend, 32'h0000_E000);
      rst = 1'b1;
      m_valid = 1'b1; m_wn = 5'd20; m_d = 32'h2020;
      step();
      rst = 1'b0;
      idle();
      check("rd_we", 32'(we), 32'd0);
      check("rd_wn", 32'(wn), 32'd0);
      check("rd_d", d, 32'd0);
      check("rd_ready", 32'(m_ready), 32'd1);
      check("rd_pend", pend, 32'd0);
      repeat (6) step();

      check("queue_empty", 32'(expq.size()), 32'd0);
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
